// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// execute-stage resolution/redirect, and branch/mispredict statistics.
module branch_predictor_btb #(
   parameter int INDEX_BITS = 6,
   parameter int XLEN       = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            BranchE,
   input  logic            BranchTakenE,
   input  logic            StallE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE,
   output logic [31:0]     BranchCount,
   output logic [31:0]     MispredictCount
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = XLEN - INDEX_BITS - 2;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [XLEN-1:0]  r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];
   logic [31:0]      r_branch_cnt;
   logic [31:0]      r_mispred_cnt;

   logic [INDEX_BITS-1:0] w_idxF, w_idxE;
   logic [TAG_W-1:0]      w_tagF, w_tagE;
   logic                  w_hitF, w_hitE, w_upd;
   logic [1:0]            w_ctrE;
   logic                  w_unused;

   assign w_idxF = PCF[INDEX_BITS+1:2];
   assign w_tagF = PCF[XLEN-1:INDEX_BITS+2];
   assign w_idxE = PCE[INDEX_BITS+1:2];
   assign w_tagE = PCE[XLEN-1:INDEX_BITS+2];
   // Byte offset within the word never participates in indexing or tagging.
   assign w_unused = ^{PCF[1:0], PCE[1:0]};

   assign w_hitF      = r_valid[w_idxF] & (r_tag[w_idxF] == w_tagF);
   assign PredTakenF  = w_hitF & r_ctr[w_idxF][1];
   assign PredTargetF = PredTakenF ? r_target[w_idxF]
                                   : PCF + {{(XLEN-3){1'b0}}, 3'b100};

   assign MispredictE = BranchE & ((PredTakenE != BranchTakenE) |
                        (PredTakenE & BranchTakenE & (PredTargetE != PCTargetE)));
   assign RedirectPCE = BranchTakenE ? PCTargetE : PCPlus4E;

   assign w_upd  = BranchE & ~StallE;
   assign w_hitE = r_valid[w_idxE] & (r_tag[w_idxE] == w_tagE);
   assign w_ctrE = r_ctr[w_idxE];

   // Fetch reads the pre-edge table, so a same-index update shows up one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (w_upd) begin
         if (w_hitE) begin
            if (BranchTakenE) begin
               if (w_ctrE != 2'b11) r_ctr[w_idxE] <= w_ctrE + 2'b01;
               r_target[w_idxE] <= PCTargetE;
            end else if (w_ctrE != 2'b00) begin
               r_ctr[w_idxE] <= w_ctrE - 2'b01;
            end
         end else if (BranchTakenE) begin
            r_valid[w_idxE]  <= 1'b1;
            r_tag[w_idxE]    <= w_tagE;
            r_target[w_idxE] <= PCTargetE;
            r_ctr[w_idxE]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else if (w_upd) begin
         r_branch_cnt <= r_branch_cnt + 32'd1;
         if (MispredictE) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

   assign BranchCount     = r_branch_cnt;
   assign MispredictCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed vector bench for branch_predictor_btb: table of per-cycle stimulus
// with hand-computed fetch/execute outputs, plus reset corner sequences.
module tb_branch_predictor_btb;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        BranchE, BranchTakenE, StallE, PredTakenE;
   logic [31:0] PCE, PCTargetE, PCPlus4E, PredTargetE;
   logic        MispredictE;
   logic [31:0] RedirectPCE, BranchCount, MispredictCount;

   int total = 0;
   int bad   = 0;

   branch_predictor_btb #(.INDEX_BITS(6), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
      .PredTargetF(PredTargetF), .BranchE(BranchE), .BranchTakenE(BranchTakenE),
      .StallE(StallE), .PCE(PCE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
      .RedirectPCE(RedirectPCE), .BranchCount(BranchCount),
      .MispredictCount(MispredictCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        br, tk, st;
      logic [31:0] pce, ptgt;
      logic        pe;
      logic [31:0] pd, pcf;
      logic        mis;
      logic [31:0] rd;
      logic        ptf;
      logic [31:0] pt, bc, mc;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(input logic br, tk, st, input logic [31:0] pce, ptgt,
                               input logic pe, input logic [31:0] pd, pcf,
                               input logic mis, input logic [31:0] rd,
                               input logic ptf, input logic [31:0] pt, bc, mc);
      vec_t v;
      v.br = br; v.tk = tk; v.st = st; v.pce = pce; v.ptgt = ptgt; v.pe = pe;
      v.pd = pd; v.pcf = pcf; v.mis = mis; v.rd = rd; v.ptf = ptf; v.pt = pt;
      v.bc = bc; v.mc = mc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic ptf, input logic [31:0] pt,
                            input logic [31:0] bc, input logic [31:0] mc);
      chk({tag, " PredTakenF"}, {31'd0, PredTakenF}, {31'd0, ptf});
      chk({tag, " PredTargetF"}, PredTargetF, pt);
      chk({tag, " BranchCount"}, BranchCount, bc);
      chk({tag, " MispredictCount"}, MispredictCount, mc);
   endtask

   initial begin
      // br tk st  pce    ptgt  pe pd     pcf          mis rd      ptf pt        bc  mc
      vecs[0]  = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h100, 0,32'h4,   0,32'h104,  0, 0);
      vecs[1]  = mk(1,1,0, 32'h100,32'h80,0,32'h0, 32'h100, 1,32'h80,  0,32'h104,  0, 0);
      vecs[2]  = mk(1,1,0, 32'h100,32'h80,1,32'h80,32'h100, 0,32'h80,  1,32'h80,   1, 1);
      vecs[3]  = mk(1,1,0, 32'h100,32'h80,1,32'h80,32'h100, 0,32'h80,  1,32'h80,   2, 1);
      vecs[4]  = mk(1,0,0, 32'h100,32'h80,1,32'h80,32'h100, 1,32'h104, 1,32'h80,   3, 1);
      vecs[5]  = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h100, 0,32'h4,   1,32'h80,   4, 2);
      vecs[6]  = mk(1,0,0, 32'h100,32'h80,1,32'h80,32'h100, 1,32'h104, 1,32'h80,   4, 2);
      vecs[7]  = mk(1,0,0, 32'h100,32'h80,0,32'h0, 32'h100, 0,32'h104, 0,32'h104,  5, 3);
      vecs[8]  = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h100, 0,32'h4,   0,32'h104,  6, 3);
      vecs[9]  = mk(1,1,0, 32'h100,32'h80,0,32'h0, 32'h100, 1,32'h80,  0,32'h104,  6, 3);
      vecs[10] = mk(1,1,0, 32'h200,32'h40,0,32'h0, 32'h100, 1,32'h40,  0,32'h104,  7, 4);
      vecs[11] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h100, 0,32'h4,   0,32'h104,  8, 5);
      vecs[12] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h200, 0,32'h4,   1,32'h40,   8, 5);
      vecs[13] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h202, 0,32'h4,   1,32'h40,   8, 5);
      vecs[14] = mk(1,1,0, 32'h200,32'h44,1,32'h40,32'h300, 1,32'h44,  0,32'h304,  8, 5);
      vecs[15] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h200, 0,32'h4,   1,32'h44,   9, 6);
      vecs[16] = mk(1,1,1, 32'h104,32'h20,0,32'h0, 32'h104, 1,32'h20,  0,32'h108,  9, 6);
      vecs[17] = mk(1,1,1, 32'h104,32'h20,0,32'h0, 32'h104, 1,32'h20,  0,32'h108,  9, 6);
      vecs[18] = mk(1,1,1, 32'h104,32'h20,0,32'h0, 32'h104, 1,32'h20,  0,32'h108,  9, 6);
      vecs[19] = mk(1,1,0, 32'h104,32'h20,0,32'h0, 32'h104, 1,32'h20,  0,32'h108,  9, 6);
      vecs[20] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h104, 0,32'h4,   1,32'h20,  10, 7);
      vecs[21] = mk(1,0,0, 32'h108,32'h0, 0,32'h0, 32'h108, 0,32'h10C, 0,32'h10C, 10, 7);
      vecs[22] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'h108, 0,32'h4,   0,32'h10C, 11, 7);
      vecs[23] = mk(0,0,0, 32'h0,  32'h0, 0,32'h0, 32'hFFFFFFFC,0,32'h4,0,32'h0,  11, 7);
      vecs[24] = mk(0,1,0, 32'h0,  32'h500,1,32'h0,32'h104, 0,32'h500, 1,32'h20,  11, 7);

      reset = 1'b1; PCF = 32'h100; BranchE = 0; BranchTakenE = 0; StallE = 0;
      PCE = 0; PCTargetE = 0; PCPlus4E = 32'h4; PredTakenE = 0; PredTargetE = 0;

      @(negedge clk);
      #1;
      chk_fetch("reset", 1'b0, 32'h104, 32'd0, 32'd0);
      chk("reset MispredictE", {31'd0, MispredictE}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         BranchE = vecs[i].br; BranchTakenE = vecs[i].tk; StallE = vecs[i].st;
         PCE = vecs[i].pce; PCTargetE = vecs[i].ptgt; PCPlus4E = vecs[i].pce + 32'd4;
         PredTakenE = vecs[i].pe; PredTargetE = vecs[i].pd; PCF = vecs[i].pcf;
         #1;
         chk($sformatf("v%0d MispredictE", i), {31'd0, MispredictE}, {31'd0, vecs[i].mis});
         chk($sformatf("v%0d RedirectPCE", i), RedirectPCE, vecs[i].rd);
         chk_fetch($sformatf("v%0d", i), vecs[i].ptf, vecs[i].pt, vecs[i].bc, vecs[i].mc);
      end

      // Asynchronous reset pulse between edges wipes table and counters at once.
      @(negedge clk);
      BranchE = 0; BranchTakenE = 0; StallE = 0; PredTakenE = 0;
      PCE = 0; PCPlus4E = 32'h4; PCF = 32'h200;
      #1;
      chk_fetch("prereset", 1'b1, 32'h44, 32'd11, 32'd7);
      #1 reset = 1'b1;
      #1;
      chk_fetch("async reset", 1'b0, 32'h204, 32'd0, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      chk_fetch("post reset", 1'b0, 32'h204, 32'd0, 32'd0);

      // Reallocation after reset predicts again on the following cycle only.
      @(negedge clk);
      BranchE = 1; BranchTakenE = 1; PCE = 32'h200; PCTargetE = 32'h60;
      PCPlus4E = 32'h204; PCF = 32'h200;
      #1;
      chk_fetch("realloc same cycle", 1'b0, 32'h204, 32'd0, 32'd0);
      @(negedge clk);
      BranchE = 0;
      #1;
      chk_fetch("realloc next cycle", 1'b1, 32'h60, 32'd1, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
